// File: rtl/noc_packet_injector.sv
// rtl/noc_packet_injector.sv - button/switch driven packet injector for the NoC ingress stream
// Optional macro INJECTOR_DEBOUNCE_BYPASS_EN: drop the debounce counters and take press
// strobes straight from the synchronizer edges (fast simulation only).
module noc_packet_injector #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_PACKET_LEN = 8,
  parameter int NET_ADDR       = 4,
  parameter int DEBOUNCE_COUNT = 1250000
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic [1:0]                        Buttons,
  input  logic [DATA_WIDTH-1:0]             Switches,
  output logic [DATA_WIDTH-1:0]             TxData,
  output logic                              TxValid,
  input  logic                              TxReady,
  output logic                              TxLast,
  output logic [$clog2(MAX_PACKET_LEN)-1:0] Count,
  output logic                              Overflow,
  output logic                              Busy
);

  localparam int CW    = $clog2(MAX_PACKET_LEN);
  localparam int DEPTH = MAX_PACKET_LEN - 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         idx;
  logic [DATA_WIDTH-1:0] header;
  logic [DATA_WIDTH-1:0] header_next;
  logic [DATA_WIDTH-1:0] stage_mem [DEPTH];
  logic [1:0]            sync1;
  logic [1:0]            sync2;
  logic [1:0]            press;
  logic                  append_ok;
  logic [CW-1:0]         count_after;
  logic                  xfer;

`ifdef INJECTOR_DEBOUNCE_BYPASS_EN
  logic [1:0] sync3;

  // Synchronize the raw buttons and keep one extra stage for edge detection
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= Buttons;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign press = sync2 & ~sync3;
`else
  localparam int DBW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_COUNT - 1);

  logic [DBW-1:0] db_cnt [2];
  logic [1:0]     level;
  logic [1:0]     level_d;

  // Two-flop synchronizer followed by a per-button stability counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= Buttons;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only debounced rising edges count as presses; releases are ignored
  assign press = level & ~level_d;
`endif

  assign xfer    = TxValid && TxReady;
  assign TxValid = (state == ST_HEADER) || (state == ST_PAYLOAD);
  assign Busy    = TxValid;

  // Append is resolved before send so a same-cycle send sees the new length
  always_comb begin
    append_ok   = press[0] && (Count != FULL);
    count_after = append_ok ? Count + 1'b1 : Count;
    header_next = '0;
    header_next[NET_ADDR-1:0] = Switches[NET_ADDR-1:0];
    header_next[15:8]         = 8'(count_after);
  end

  // Staging buffer write; no reset needed since Count gates every read
  always_ff @(posedge Clock) begin
    if (!Reset && state == ST_IDLE && append_ok) stage_mem[Count] <= Switches;
  end

  // Packet sequencer: collect in IDLE, then stream header and payload
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_IDLE;
      Count    <= '0;
      Overflow <= 1'b0;
      idx      <= '0;
      header   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          Count <= count_after;
          if (press[0] && !append_ok) Overflow <= 1'b1;
          if (press[1]) begin
            header <= header_next;
            state  <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (xfer) begin
            idx   <= '0;
            state <= (Count == '0) ? ST_IDLE : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            if (idx == Count - 1'b1) begin
              state    <= ST_IDLE;
              Count    <= '0;
              Overflow <= 1'b0;
              idx      <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stream word and last flag derive from held state, so they are stable under stall
  always_comb begin
    TxData = '0;
    TxLast = 1'b0;
    case (state)
      ST_HEADER: begin
        TxData = header;
        TxLast = (Count == '0);
      end
      ST_PAYLOAD: begin
        TxData = stage_mem[idx];
        TxLast = (idx == Count - 1'b1);
      end
      default: begin
        TxData = '0;
        TxLast = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_noc_packet_injector.sv
// tb/tb_noc_packet_injector.sv - directed bench for noc_packet_injector
module tb_noc_packet_injector;

  logic        Clock;
  logic        Reset;
  logic [1:0]  Buttons;
  logic [31:0] Switches;
  logic [31:0] TxData;
  logic        TxValid;
  logic        TxReady;
  logic        TxLast;
  logic [2:0]  Count;
  logic        Overflow;
  logic        Busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_data [16];
  logic        got_last [16];
  int          got_n;
  int          got_cyc;

  noc_packet_injector #(
    .DATA_WIDTH(32), .MAX_PACKET_LEN(8), .NET_ADDR(4), .DEBOUNCE_COUNT(4)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Buttons(Buttons), .Switches(Switches),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady), .TxLast(TxLast),
    .Count(Count), .Overflow(Overflow), .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int b, input int hold);
    Buttons[b] = 1'b1;
    idle(hold);
    Buttons[b] = 1'b0;
  endtask

  task automatic append(input logic [31:0] v);
    Switches = v;
    press(0, 8);
    idle(8);
  endtask

  task automatic send(input logic [31:0] sw);
    TxReady  = 1'b0;
    Switches = sw;
    press(1, 8);
  endtask

  task automatic capture(input int budget);
    bit done;
    done    = 0;
    got_n   = 0;
    got_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      got_data[i] = 'x;
      got_last[i] = 1'bx;
    end
    TxReady = 1'b1;
    while (!done && got_cyc < budget) begin
      if (TxValid && got_n < 16) begin
        got_data[got_n] = TxData;
        got_last[got_n] = TxLast;
        got_n++;
        if (TxLast) done = 1;
      end
      tick();
      got_cyc++;
    end
    TxReady = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Buttons = '0; Switches = '0; TxReady = 1'b0;
    idle(3);
    checks++; if ({TxValid, TxLast, Busy, Overflow} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {TxValid, TxLast, Busy, Overflow}); end
    checks++; if (TxData !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", TxData); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", Count); end
    Reset = 1'b0;
    idle(2);
  endtask

  task automatic test_debounce();
    Switches = 32'hA5A5_0001;
    Buttons[0] = 1'b1;
    idle(2);
    Buttons[0] = 1'b0;
    idle(10);
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL glitch_reject: Count got %0d want 0", Count); end
    press(0, 10);
    idle(8);
    checks++; if (Count !== 3'd1) begin errors++; $display("FAIL debounced_append: Count got %0d want 1", Count); end
  endtask

  task automatic test_basic_packet();
    append(32'h0000_0002);
    checks++; if (Count !== 3'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", Count); end
    send(32'h0000_0003);
    capture(10);
    checks++; if (got_n !== 3) begin errors++; $display("FAIL basic_len: got %0d want 3", got_n); end
    checks++; if (got_cyc !== 3) begin errors++; $display("FAIL basic_back_to_back: cycles %0d want 3", got_cyc); end
    checks++; if (got_data[0] !== 32'h0000_0203) begin errors++; $display("FAIL basic_hdr: got %h want 00000203", got_data[0]); end
    checks++; if (got_data[1] !== 32'hA5A5_0001) begin errors++; $display("FAIL basic_w1: got %h want a5a50001", got_data[1]); end
    checks++; if (got_data[2] !== 32'h0000_0002) begin errors++; $display("FAIL basic_w2: got %h want 00000002", got_data[2]); end
    checks++; if ({got_last[0], got_last[1], got_last[2]} !== 3'b001) begin errors++; $display("FAIL basic_last: got %b want 001", {got_last[0], got_last[1], got_last[2]}); end
    checks++; if ({Count, Busy, TxValid} !== 5'b00000) begin errors++; $display("FAIL basic_after: Count %0d Busy %b TxValid %b want 0 0 0", Count, Busy, TxValid); end
    idle(10);
  endtask

  task automatic test_empty_packet();
    send(32'h0000_0009);
    capture(10);
    checks++; if (got_n !== 1) begin errors++; $display("FAIL empty_len: got %0d want 1", got_n); end
    checks++; if (got_data[0] !== 32'h0000_0009) begin errors++; $display("FAIL empty_hdr: got %h want 00000009", got_data[0]); end
    checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL empty_last: got %b want 1", got_last[0]); end
    idle(10);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) append(32'h0000_0100 + i);
    checks++; if (Count !== 3'd7) begin errors++; $display("FAIL ovf_count: got %0d want 7", Count); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", Overflow); end
    send(32'h0000_000F);
    capture(20);
    checks++; if (got_n !== 8) begin errors++; $display("FAIL ovf_len: got %0d want 8", got_n); end
    checks++; if (got_data[0] !== 32'h0000_070F) begin errors++; $display("FAIL ovf_hdr: got %h want 0000070f", got_data[0]); end
    checks++; if (got_data[1] !== 32'h0000_0100) begin errors++; $display("FAIL ovf_first: got %h want 00000100", got_data[1]); end
    checks++; if (got_data[7] !== 32'h0000_0106) begin errors++; $display("FAIL ovf_seventh: got %h want 00000106", got_data[7]); end
    checks++; if ({got_last[6], got_last[7]} !== 2'b01) begin errors++; $display("FAIL ovf_last: got %b want 01", {got_last[6], got_last[7]}); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b want 0", Overflow); end
    idle(10);
  endtask

  task automatic test_stall();
    logic [31:0] exp [4];
    int n;
    exp[0] = 32'h0000_030A;
    exp[1] = 32'hC0DE_0001;
    exp[2] = 32'hC0DE_0002;
    exp[3] = 32'hC0DE_0003;
    for (int i = 1; i <= 3; i++) append(32'hC0DE_0000 + i);
    send(32'h0000_000A);
    press(0, 8);
    idle(8);
    checks++; if (Count !== 3'd3) begin errors++; $display("FAIL busy_press_ignored: Count got %0d want 3", Count); end
    checks++; if ({TxValid, Busy} !== 2'b11 || TxData !== exp[0]) begin errors++; $display("FAIL stall_hold: valid %b data %h want 1 %h", TxValid, TxData, exp[0]); end
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      TxReady = cyc[0];
      if (TxValid) begin
        checks++; if (TxData !== exp[n] || TxLast !== (n == 3)) begin errors++; $display("FAIL stall_word%0d: data %h last %b want %h %b", n, TxData, TxLast, exp[n], n == 3); end
        if (TxReady) n++;
      end
      tick();
    end
    TxReady = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL stall_count: transfers %0d want 4", n); end
    idle(10);
    checks++; if ({TxValid, Count} !== 4'b0000) begin errors++; $display("FAIL stall_after: valid %b Count %0d want 0 0", TxValid, Count); end
  endtask

  task automatic test_reset_mid_packet();
    append(32'h0000_00D1);
    append(32'h0000_00D2);
    send(32'h0000_0000);
    TxReady = 1'b1;
    tick();
    tick();
    TxReady = 1'b0;
    checks++; if (TxValid !== 1'b1 || TxData !== 32'h0000_00D2) begin errors++; $display("FAIL mid_second_word: valid %b data %h want 1 000000d2", TxValid, TxData); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if ({TxValid, Busy, Count} !== 5'b00000) begin errors++; $display("FAIL mid_reset: valid %b busy %b Count %0d want 0 0 0", TxValid, Busy, Count); end
    idle(10);
    send(32'h0000_0005);
    capture(10);
    checks++; if (got_n !== 1 || got_data[0] !== 32'h0000_0005 || got_last[0] !== 1'b1) begin errors++; $display("FAIL mid_resend: n %0d data %h last %b want 1 00000005 1", got_n, got_data[0], got_last[0]); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_basic_packet();
    test_empty_packet();
    test_overflow();
    test_stall();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
